// File: rtl/mips_memory_access_controller_pkg.sv
// mips_memory_access_controller_pkg: shared encodings for the memory-stage sequencer
package mips_memory_access_controller_pkg;
    typedef enum logic [2:0] {
        CAT_ALU    = 3'd0,
        CAT_LOAD   = 3'd1,
        CAT_STORE  = 3'd2,
        CAT_BRANCH = 3'd3,
        CAT_JUMP   = 3'd4,
        CAT_SYSTEM = 3'd5
    } category_T;
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_T;
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_T;
    function automatic int bytes_of(input int data_width);
        return data_width / 8;
    endfunction
endpackage

// File: rtl/mips_memory_lane_align.sv
// mips_memory_lane_align: byte enables, store lane replication and load extract/extend
//   size/offset/sign_extend in: access size, byte offset within the bus word, load extension mode
//   store_data/read_data in: right-justified store value, raw bus read data
//   byte_enable/write_data/load_data out: active lanes, replicated store data, extended load value
module mips_memory_lane_align
    import mips_memory_access_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int OFS_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic [1:0]              size,
    input  logic [OFS_W-1:0]        offset,
    input  logic                    sign_extend,
    input  logic [DATA_WIDTH-1:0]   store_data,
    input  logic [DATA_WIDTH-1:0]   read_data,
    output logic [DATA_WIDTH/8-1:0] byte_enable,
    output logic [DATA_WIDTH-1:0]   write_data,
    output logic [DATA_WIDTH-1:0]   load_data
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    logic [OFS_W:0]        span;
    logic [OFS_W:0]        base;
    logic [DATA_WIDTH-1:0] shifted;
    always_comb begin
        span = size == SIZE_HALF ? (OFS_W+1)'(2) : size == SIZE_WORD ? (OFS_W+1)'(4) : (OFS_W+1)'(1);
        // big-endian mirrors the whole element: lowest lane used is BYTES - offset - span
        base = BIG_ENDIAN ? (OFS_W+1)'(BYTES) - span - {1'b0, offset} : {1'b0, offset};
        byte_enable = BYTES'((1 << span) - 1) << base;
        shifted = read_data >> {base, 3'b000};
        write_data = size == SIZE_BYTE ? DATA_WIDTH'({BYTES{store_data[7:0]}}) :
                     size == SIZE_HALF ? DATA_WIDTH'({(BYTES/2){store_data[15:0]}}) :
                                         DATA_WIDTH'({(BYTES/4){store_data[31:0]}});
        load_data = size == SIZE_BYTE ? (sign_extend ? DATA_WIDTH'($signed(shifted[7:0]))  : DATA_WIDTH'(shifted[7:0])) :
                    size == SIZE_HALF ? (sign_extend ? DATA_WIDTH'($signed(shifted[15:0])) : DATA_WIDTH'(shifted[15:0])) :
                                        (sign_extend ? DATA_WIDTH'($signed(shifted[31:0])) : DATA_WIDTH'(shifted[31:0]));
    end
endmodule

// File: rtl/mips_memory_access_controller.sv
// mips_memory_access_controller: memory-stage sequencer turning EX/MEM loads/stores into bus transactions
//   clock/reset: rising edge, synchronous active-high
//   valid/category/size/signExtend/flush/address/storeData: EX/MEM instruction fields
//   memRequest/memWrite/memByteEnable/memAddress/memWriteData/memReady/memReadData: data-memory bus
//   stall/resultValid/loadData/addressError/busError: pipeline-side status and results
module mips_memory_access_controller
    import mips_memory_access_controller_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit BIG_ENDIAN = 1'b0,
    parameter int TIMEOUT    = 15
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    valid,
    input  category_T               category,
    input  logic [1:0]              size,
    input  logic                    signExtend,
    input  logic                    flush,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   storeData,
    output logic                    memRequest,
    output logic                    memWrite,
    output logic [DATA_WIDTH/8-1:0] memByteEnable,
    output logic [ADDR_WIDTH-1:0]   memAddress,
    output logic [DATA_WIDTH-1:0]   memWriteData,
    input  logic                    memReady,
    input  logic [DATA_WIDTH-1:0]   memReadData,
    output logic                    stall,
    output logic                    resultValid,
    output logic [DATA_WIDTH-1:0]   loadData,
    output logic                    addressError,
    output logic                    busError
);
    localparam int BYTES = bytes_of(DATA_WIDTH);
    localparam int OFS_W = $clog2(BYTES);
    localparam int CW    = $clog2(TIMEOUT + 1);
    state_T            state, next_state;
    logic [CW-1:0]     cnt;
    logic              squash, is_mem, aligned, start, bad_access, timeout, done;
    logic [1:0]        size_q, al_size;
    logic [OFS_W-1:0]  ofs_q, al_ofs;
    logic              sext_q, al_sext;
    logic [BYTES-1:0]      be;
    logic [DATA_WIDTH-1:0] wd, ld;
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end
    always_comb begin
        next_state = start ? BUSY : (state == BUSY && (memReady || timeout)) ? IDLE : state;
    end
    always_comb begin
        is_mem     = valid & (category == CAT_LOAD | category == CAT_STORE);
        aligned    = size == SIZE_BYTE | (size == SIZE_HALF & !address[0]) | (size == SIZE_WORD & address[1:0] == 2'b00);
        start      = state == IDLE & is_mem & aligned & !flush;
        bad_access = state == IDLE & is_mem & !aligned & !flush;
        timeout    = state == BUSY & !memReady & cnt == CW'(TIMEOUT - 1);
        done       = state == BUSY & memReady;
        stall      = start | (state == BUSY & !memReady & !timeout);
        // while busy the instruction fields are taken from the copy latched at acceptance
        al_size    = state == BUSY ? size_q : size;
        al_ofs     = state == BUSY ? ofs_q : address[OFS_W-1:0];
        al_sext    = state == BUSY ? sext_q : signExtend;
    end
    mips_memory_lane_align #(
        .DATA_WIDTH (DATA_WIDTH),
        .BIG_ENDIAN (BIG_ENDIAN),
        .OFS_W      (OFS_W)
    ) u_align (
        .size        (al_size),
        .offset      (al_ofs),
        .sign_extend (al_sext),
        .store_data  (storeData),
        .read_data   (memReadData),
        .byte_enable (be),
        .write_data  (wd),
        .load_data   (ld)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt           <= '0;
            squash        <= 1'b0;
            size_q        <= '0;
            ofs_q         <= '0;
            sext_q        <= 1'b0;
            memRequest    <= 1'b0;
            memWrite      <= 1'b0;
            memByteEnable <= '0;
            memAddress    <= '0;
            memWriteData  <= '0;
            resultValid   <= 1'b0;
            loadData      <= '0;
            addressError  <= 1'b0;
            busError      <= 1'b0;
        end else begin
            resultValid  <= done & !(squash | flush);
            addressError <= bad_access;
            busError     <= timeout;
            // a flush seen while busy is remembered until the transaction ends
            squash       <= state == BUSY & !done & !timeout & (squash | flush);
            cnt          <= start ? '0 : (state == BUSY & !memReady) ? cnt + 1'b1 : cnt;
            if (start) begin
                memRequest    <= 1'b1;
                memWrite      <= category == CAT_STORE;
                memByteEnable <= be;
                memAddress    <= {address[ADDR_WIDTH-1:OFS_W], OFS_W'(0)};
                memWriteData  <= wd;
                size_q        <= size;
                ofs_q         <= address[OFS_W-1:0];
                sext_q        <= signExtend;
            end else if (done | timeout) begin
                memRequest    <= 1'b0;
                memWrite      <= 1'b0;
                memByteEnable <= '0;
            end
            if (done & !memWrite & !(squash | flush))
                loadData <= ld;
        end
    end
endmodule

// File: tb/tb_mips_memory_access_controller.sv
// tb_mips_memory_access_controller: directed self-checking bench for the memory-stage sequencer
module tb_mips_memory_access_controller;
    import mips_memory_access_controller_pkg::*;
    logic        clock = 1'b0, reset = 1'b1, valid = 1'b0, signExtend = 1'b0, flush = 1'b0, memReady = 1'b0;
    category_T   category = CAT_ALU;
    logic [1:0]  size = 2'b00;
    logic [31:0] address = '0, storeData = '0, memReadData = '0;
    logic        memRequest, memWrite, stall, resultValid, addressError, busError;
    logic [3:0]  memByteEnable;
    logic [31:0] memAddress, memWriteData, loadData;
    logic        memRequest_b, memWrite_b, stall_b, resultValid_b, addressError_b, busError_b;
    logic [3:0]  memByteEnable_b;
    logic [31:0] memAddress_b, memWriteData_b, loadData_b;
    int checks = 0, errors = 0;
    int n_req;
    logic seen;
    always #5 clock = ~clock;
    mips_memory_access_controller dut (
        .clock(clock), .reset(reset), .valid(valid), .category(category), .size(size),
        .signExtend(signExtend), .flush(flush), .address(address), .storeData(storeData),
        .memRequest(memRequest), .memWrite(memWrite), .memByteEnable(memByteEnable),
        .memAddress(memAddress), .memWriteData(memWriteData), .memReady(memReady),
        .memReadData(memReadData), .stall(stall), .resultValid(resultValid),
        .loadData(loadData), .addressError(addressError), .busError(busError)
    );
    mips_memory_access_controller #(.BIG_ENDIAN(1'b1)) dut_be (
        .clock(clock), .reset(reset), .valid(valid), .category(category), .size(size),
        .signExtend(signExtend), .flush(flush), .address(address), .storeData(storeData),
        .memRequest(memRequest_b), .memWrite(memWrite_b), .memByteEnable(memByteEnable_b),
        .memAddress(memAddress_b), .memWriteData(memWriteData_b), .memReady(memReady),
        .memReadData(memReadData), .stall(stall_b), .resultValid(resultValid_b),
        .loadData(loadData_b), .addressError(addressError_b), .busError(busError_b)
    );
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic issue(input category_T c, input logic [1:0] s, input logic sx, input logic [31:0] a, input logic [31:0] d);
        valid = 1'b1;
        category = c;
        size = s;
        signExtend = sx;
        address = a;
        storeData = d;
        #1;
    endtask
    initial begin
        tick;
        tick;
        chk("rst_req", 32'(memRequest), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_rv", 32'(resultValid), 0);
        chk("rst_load", loadData, 0);
        chk("rst_aerr", 32'(addressError), 0);
        chk("rst_berr", 32'(busError), 0);
        reset = 1'b0;
        // sw 0x1004 with one wait state
        issue(CAT_STORE, SIZE_WORD, 1'b0, 32'h1004, 32'hDEADBEEF);
        chk("sw_stall_accept", 32'(stall), 1);
        tick; valid = 1'b0; #1;
        chk("sw_req", 32'(memRequest), 1);
        chk("sw_write", 32'(memWrite), 1);
        chk("sw_be", 32'(memByteEnable), 32'hF);
        chk("sw_addr", memAddress, 32'h1004);
        chk("sw_wdata", memWriteData, 32'hDEADBEEF);
        chk("sw_stall_wait", 32'(stall), 1);
        tick; memReady = 1'b1; #1;
        chk("sw_stall_ready", 32'(stall), 0);
        chk("sw_rv_early", 32'(resultValid), 0);
        tick; memReady = 1'b0; #1;
        chk("sw_rv", 32'(resultValid), 1);
        chk("sw_req_drop", 32'(memRequest), 0);
        tick;
        chk("sw_rv_pulse", 32'(resultValid), 0);
        // lb 0x2003 sign-extended, both endiannesses
        issue(CAT_LOAD, SIZE_BYTE, 1'b1, 32'h2003, 32'h0);
        chk("lb_stall_accept", 32'(stall), 1);
        tick; valid = 1'b0; memReady = 1'b1; memReadData = 32'h80112233; #1;
        chk("lb_be", 32'(memByteEnable), 32'h8);
        chk("lb_be_big", 32'(memByteEnable_b), 32'h1);
        chk("lb_addr", memAddress, 32'h2000);
        chk("lb_write", 32'(memWrite), 0);
        tick; memReady = 1'b0; #1;
        chk("lb_rv", 32'(resultValid), 1);
        chk("lb_data", loadData, 32'hFFFFFF80);
        chk("lb_rv_big", 32'(resultValid_b), 1);
        chk("lb_data_big", loadData_b, 32'h00000033);
        tick;
        // sh 0x3001 misaligned
        issue(CAT_STORE, SIZE_HALF, 1'b0, 32'h3001, 32'h1234);
        chk("sh_stall", 32'(stall), 0);
        tick; valid = 1'b0; #1;
        chk("sh_aerr", 32'(addressError), 1);
        chk("sh_req", 32'(memRequest), 0);
        tick;
        chk("sh_aerr_pulse", 32'(addressError), 0);
        chk("sh_req_after", 32'(memRequest), 0);
        // lw 0x4000 with three wait states
        issue(CAT_LOAD, SIZE_WORD, 1'b0, 32'h4000, 32'h0);
        chk("lw_stall_accept", 32'(stall), 1);
        tick; valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("lw_wait_stall", 32'(stall), 1);
            chk("lw_hold_addr", memAddress, 32'h4000);
            chk("lw_hold_req", 32'(memRequest), 1);
            tick;
        end
        memReady = 1'b1; memReadData = 32'h12345678; #1;
        chk("lw_stall_ready", 32'(stall), 0);
        tick; memReady = 1'b0; #1;
        chk("lw_rv", 32'(resultValid), 1);
        chk("lw_data", loadData, 32'h12345678);
        tick;
        chk("lw_rv_once", 32'(resultValid), 0);
        // lw 0x5000 never answered
        issue(CAT_LOAD, SIZE_WORD, 1'b0, 32'h5000, 32'h0);
        tick; valid = 1'b0;
        n_req = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #1;
            if (busError) seen = 1'b1;
            else begin
                if (memRequest) n_req++;
                tick;
            end
        end
        chk("be_seen", 32'(seen), 1);
        chk("be_cycles", n_req, 15);
        chk("be_req_drop", 32'(memRequest), 0);
        chk("be_no_rv", 32'(resultValid), 0);
        tick;
        chk("be_pulse", 32'(busError), 0);
        // flush during a busy store
        issue(CAT_STORE, SIZE_WORD, 1'b0, 32'h6000, 32'h11223344);
        tick; valid = 1'b0; flush = 1'b1; #1;
        chk("fl_req", 32'(memRequest), 1);
        chk("fl_write", 32'(memWrite), 1);
        tick; flush = 1'b0; memReady = 1'b1; #1;
        chk("fl_req_held", 32'(memRequest), 1);
        chk("fl_wdata", memWriteData, 32'h11223344);
        tick; memReady = 1'b0; #1;
        chk("fl_rv", 32'(resultValid), 0);
        chk("fl_req_drop", 32'(memRequest), 0);
        // reset while busy
        issue(CAT_LOAD, SIZE_WORD, 1'b0, 32'h7000, 32'h0);
        tick; valid = 1'b0; #1;
        chk("mr_req_busy", 32'(memRequest), 1);
        reset = 1'b1;
        tick; reset = 1'b0; #1;
        chk("mr_req", 32'(memRequest), 0);
        chk("mr_stall_idle", 32'(stall), 0);
        // sb 0x0002 then lhu 0x0002
        issue(CAT_STORE, SIZE_BYTE, 1'b0, 32'h0002, 32'h000000AB);
        tick; valid = 1'b0; #1;
        chk("sb_wdata", memWriteData, 32'hABABABAB);
        chk("sb_be", 32'(memByteEnable), 32'h4);
        memReady = 1'b1;
        tick; memReady = 1'b0; #1;
        chk("sb_rv", 32'(resultValid), 1);
        issue(CAT_LOAD, SIZE_HALF, 1'b0, 32'h0002, 32'h0);
        tick; valid = 1'b0; memReady = 1'b1; memReadData = 32'hBEEF0000; #1;
        chk("lhu_be", 32'(memByteEnable), 32'hC);
        tick; memReady = 1'b0; #1;
        chk("lhu_rv", 32'(resultValid), 1);
        chk("lhu_data", loadData, 32'h0000BEEF);
        // non-memory instruction
        issue(CAT_ALU, SIZE_WORD, 1'b0, 32'h0, 32'h0);
        chk("alu_stall", 32'(stall), 0);
        tick; valid = 1'b0; #1;
        chk("alu_req", 32'(memRequest), 0);
        // flush in idle hides a misaligned access
        flush = 1'b1;
        issue(CAT_LOAD, SIZE_HALF, 1'b0, 32'h8001, 32'h0);
        chk("fi_stall", 32'(stall), 0);
        tick; valid = 1'b0; flush = 1'b0; #1;
        chk("fi_aerr", 32'(addressError), 0);
        chk("fi_req", 32'(memRequest), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
